// File: rtl/dmem_line_responder_if.sv
// dmem_line_responder_if: cache-to-memory line traffic bundle.
interface dmem_line_responder_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int WORDS_PER_LINE = 8
);
    localparam int IB = $clog2(WORDS_PER_LINE);
    logic              load;
    logic              writeback;
    logic [ADDR_W-1:0] line_addr;
    logic [DATA_W-1:0] wb_data;
    logic              wb_take;
    logic [IB-1:0]     wb_idx;
    logic [DATA_W-1:0] fill_data;
    logic              fill_valid;
    logic [IB-1:0]     fill_idx;
    logic              busy;
    logic              done;
    modport master (
        output load, writeback, line_addr, wb_data,
        input  wb_take, wb_idx, fill_data, fill_valid, fill_idx, busy, done
    );
    modport slave (
        input  load, writeback, line_addr, wb_data,
        output wb_take, wb_idx, fill_data, fill_valid, fill_idx, busy, done
    );
endinterface

// File: rtl/dmem_line_responder.sv
// dmem_line_responder: fixed-latency line fill / writeback responder over a word RAM.
module dmem_line_responder #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int WORDS_PER_LINE = 8,
    parameter int LAT = 4,
    parameter int DEPTH_WORDS = 16384
) (
    input logic CLK,
    input logic RST,
    dmem_line_responder_if.slave bus
);
    localparam int IB = $clog2(WORDS_PER_LINE);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int LCW = LAT > 1 ? $clog2(LAT) : 1;
    localparam logic [2:0] IDLE = 3'd0, LATENCY = 3'd1, FILL = 3'd2, WB = 3'd3, DONE = 3'd4;
    logic [2:0] state;
    logic [LCW-1:0] lat_cnt;
    logic [IB-1:0] beat;
    logic [AW-IB-1:0] line;
    logic is_wb;
    logic req;
    logic unused_addr;
    logic [AW-1:0] addr;
    logic [DATA_W-1:0] ram [DEPTH_WORDS];
    assign req = bus.load | bus.writeback;
    assign addr = {line, beat};
    assign unused_addr = ^bus.line_addr;
    always_ff @(posedge CLK)
        if (RST) begin
            state   <= IDLE;
            lat_cnt <= '0;
            beat    <= '0;
            line    <= '0;
            is_wb   <= 1'b0;
        end else
            case (state)
                IDLE: if (req) begin
                    // word address with the line offset dropped; upper bits wrap the RAM
                    line    <= bus.line_addr[2+IB +: AW-IB];
                    is_wb   <= bus.writeback;
                    beat    <= '0;
                    lat_cnt <= LCW'(LAT > 0 ? LAT - 1 : 0);
                    state   <= LAT > 0 ? LATENCY : bus.writeback ? WB : FILL;
                end
                LATENCY: if (lat_cnt == '0) state <= is_wb ? WB : FILL;
                         else lat_cnt <= lat_cnt - 1'b1;
                FILL, WB: begin
                    beat <= beat + 1'b1;
                    if (&beat) state <= DONE;
                end
                default: state <= IDLE;
            endcase
    always_ff @(posedge CLK)
        if (!RST && state == WB) ram[addr] <= bus.wb_data;
    assign bus.wb_take    = state == WB;
    assign bus.wb_idx     = state == WB ? beat : '0;
    assign bus.fill_valid = state == FILL;
    assign bus.fill_idx   = state == FILL ? beat : '0;
    assign bus.fill_data  = state == FILL ? ram[addr] : '0;
    assign bus.busy       = state != IDLE;
    assign bus.done       = state == DONE;
endmodule

// File: tb/tb_dmem_line_responder.sv
// tb_dmem_line_responder: directed checks on a LAT=4 and a LAT=0 responder.
module tb_dmem_line_responder;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    int errors = 0;
    int checks = 0;
    logic [31:0] wb_base = '0;
    always #5 CLK = ~CLK;

    dmem_line_responder_if b0 ();
    dmem_line_responder_if b1 ();
    dmem_line_responder #(.LAT(4)) dut0 (.CLK(CLK), .RST(RST), .bus(b0));
    dmem_line_responder #(.LAT(0)) dut1 (.CLK(CLK), .RST(RST), .bus(b1));
    assign b0.wb_data = wb_base + 32'(b0.wb_idx);
    assign b1.wb_data = wb_base + 32'(b1.wb_idx);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int u, input logic w, input logic l, input logic [31:0] a);
        if (u == 1) begin b1.writeback = w; b1.load = l; b1.line_addr = a; end
        else begin b0.writeback = w; b0.load = l; b0.line_addr = a; end
    endtask

    // Request raised in IDLE cycle 0; beats at cycles lat+1..lat+8, done at lat+9.
    task automatic txn(input int u, input logic w, input logic l, input logic [31:0] a,
                       input logic [31:0] d, input logic exp_wb);
        int lat = u == 1 ? 0 : 4;
        wb_base = d;
        drive(u, w, l, a);
        for (int c = 1; c <= lat + 9; c++) begin
            logic beat;
            logic [31:0] k;
            @(negedge CLK);
            beat = c > lat && c <= lat + 8;
            k = beat ? 32'(c - lat - 1) : 32'd0;
            check($sformatf("busy c%0d", c), u == 1 ? b1.busy : b0.busy, 1);
            check($sformatf("done c%0d", c), u == 1 ? b1.done : b0.done, 32'(c == lat + 9));
            check($sformatf("wb_take c%0d", c), u == 1 ? b1.wb_take : b0.wb_take, 32'(exp_wb && beat));
            check($sformatf("wb_idx c%0d", c), 32'(u == 1 ? b1.wb_idx : b0.wb_idx), exp_wb ? k : 0);
            check($sformatf("fill_valid c%0d", c), u == 1 ? b1.fill_valid : b0.fill_valid, 32'(!exp_wb && beat));
            check($sformatf("fill_idx c%0d", c), 32'(u == 1 ? b1.fill_idx : b0.fill_idx), exp_wb ? 0 : k);
            check($sformatf("fill_data c%0d", c), u == 1 ? b1.fill_data : b0.fill_data,
                  (!exp_wb && beat) ? d + k : 32'd0);
            if (c == 2) drive(u, w, l, 32'h0000_0F00);
            if (c == lat + 9) drive(u, 0, 0, 32'h0);
        end
        @(negedge CLK);
        check("idle busy", u == 1 ? b1.busy : b0.busy, 0);
    endtask

    initial begin
        drive(0, 0, 0, 0);
        drive(1, 0, 0, 0);
        repeat (2) @(negedge CLK);
        check("rst busy", b0.busy, 0);
        check("rst done", b0.done, 0);
        check("rst fill_valid", b0.fill_valid, 0);
        check("rst wb_take", b0.wb_take, 0);
        check("rst fill_data", b0.fill_data, 0);
        RST = 1'b0;
        // preload then fill
        txn(0, 1, 0, 32'h100, 32'hA0, 1);
        txn(0, 0, 1, 32'h104, 32'hA0, 0);
        // writeback then fill of the same line
        txn(0, 1, 0, 32'h200, 32'hD0, 1);
        txn(0, 0, 1, 32'h21C, 32'hD0, 0);
        // simultaneous requests: writeback wins
        txn(0, 1, 1, 32'h300, 32'h50, 1);
        txn(0, 0, 1, 32'h300, 32'h50, 0);
        // address wrap lands on words 8..15
        txn(0, 1, 0, 32'h0001_0020, 32'hE0, 1);
        txn(0, 0, 1, 32'h0000_0020, 32'hE0, 0);
        // reset during fill beat 3
        drive(0, 0, 1, 32'h100);
        repeat (8) @(negedge CLK);
        check("pre-rst fill_idx", 32'(b0.fill_idx), 3);
        RST = 1'b1;
        drive(0, 0, 0, 0);
        @(negedge CLK);
        check("rst mid busy", b0.busy, 0);
        check("rst mid fill_valid", b0.fill_valid, 0);
        check("rst mid done", b0.done, 0);
        @(negedge CLK);
        RST = 1'b0;
        txn(0, 0, 1, 32'h100, 32'hA0, 0);
        // zero-latency instance
        txn(1, 1, 0, 32'h400, 32'h70, 1);
        txn(1, 0, 1, 32'h410, 32'h70, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
